// File: rtl/periph_bus_pkg.sv
// Shared types and constants for the peripheral bus arbiter.
// Bus widths, FSM state encoding and the error word returned on a watchdog abort.
package periph_bus_pkg;

    localparam int BUS_AW = 32;
    localparam int BUS_DW = 32;
    localparam int BUS_SW = 4;

    localparam logic [BUS_DW-1:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first requesting index strictly after
// last_grant, wrapping around. winner is only meaningful while any_req is high.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last_grant,
    output logic [$clog2(N)-1:0] winner,
    output logic                 any_req
);

    localparam int IW = $clog2(N);

    int   cand_s;
    logic found_s;

    // Scan N positions starting just after the previous grant; first hit wins.
    always_comb begin
        winner  = last_grant;
        found_s = 1'b0;
        cand_s  = 0;
        for (int off = 1; off <= N; off++) begin
            cand_s = (int'(last_grant) + off) % N;
            if (!found_s && req[cand_s]) begin
                winner  = IW'(cand_s);
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/periph_bus_arbiter.sv
// Round-robin arbiter sharing one peripheral bus between NUM_HOSTS requesters,
// one outstanding access, registered response and a stall watchdog.
module periph_bus_arbiter
    import periph_bus_pkg::*;
#(
    parameter int NUM_HOSTS      = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        sys_clk,
    input  logic                        rst,
    input  logic [NUM_HOSTS-1:0]        host_valid,
    output logic [NUM_HOSTS-1:0]        host_ready,
    input  logic [NUM_HOSTS*BUS_AW-1:0] host_addr,
    input  logic [NUM_HOSTS*BUS_DW-1:0] host_wdata,
    input  logic [NUM_HOSTS*BUS_SW-1:0] host_wstrb,
    output logic [BUS_DW-1:0]           host_rdata,
    output logic                        periph_valid,
    input  logic                        periph_ready,
    output logic [BUS_AW-1:0]           periph_addr,
    output logic [BUS_DW-1:0]           periph_wdata,
    output logic [BUS_SW-1:0]           periph_wstrb,
    input  logic [BUS_DW-1:0]           periph_rdata,
    output logic                        timeout_err,
    output logic [BUS_AW-1:0]           timeout_addr
);

    localparam int IDX_W = $clog2(NUM_HOSTS);
    localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_HOSTS-1:0] HOST0_MASK = {{(NUM_HOSTS-1){1'b0}}, 1'b1};

    arb_state_e             state_r;
    arb_state_e             state_n_s;
    logic [IDX_W-1:0]       grant_r;
    logic [IDX_W-1:0]       last_grant_r;
    logic [IDX_W-1:0]       winner_s;
    logic                   any_req_s;
    logic [15:0]            wdog_cnt_r;
    logic                   complete_s;
    logic                   timeout_s;
    logic                   periph_valid_r;
    logic [NUM_HOSTS-1:0]   host_ready_r;
    logic [BUS_DW-1:0]      host_rdata_r;
    logic                   timeout_err_r;
    logic [BUS_AW-1:0]      timeout_addr_r;

    rr_arbiter #(
        .N (NUM_HOSTS)
    ) u_rr_arbiter (
        .req        (host_valid),
        .last_grant (last_grant_r),
        .winner     (winner_s),
        .any_req    (any_req_s)
    );

    assign periph_addr  = host_addr[int'(grant_r)*BUS_AW +: BUS_AW];
    assign periph_wdata = host_wdata[int'(grant_r)*BUS_DW +: BUS_DW];
    assign periph_wstrb = host_wstrb[int'(grant_r)*BUS_SW +: BUS_SW];

    // Peripheral completion wins over a watchdog expiry in the same cycle.
    always_comb begin
        complete_s = (state_r == BUSY) && periph_ready;
        timeout_s  = (state_r == BUSY) && !periph_ready && (wdog_cnt_r == WDOG_LIMIT);
        state_n_s  = state_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    state_n_s = BUSY;
                end else begin
                    state_n_s = IDLE;
                end
            end
            BUSY: begin
                if (complete_s || timeout_s) begin
                    state_n_s = DONE;
                end else begin
                    state_n_s = BUSY;
                end
            end
            DONE:    state_n_s = IDLE;
            default: state_n_s = IDLE;
        endcase
    end

    // State, grant bookkeeping and watchdog counter.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_r        <= IDLE;
            grant_r        <= '0;
            last_grant_r   <= IDX_W'(NUM_HOSTS - 1);
            wdog_cnt_r     <= 16'd0;
            periph_valid_r <= 1'b0;
        end else begin
            state_r        <= state_n_s;
            periph_valid_r <= (state_n_s == BUSY);
            if ((state_r == IDLE) && any_req_s) begin
                grant_r      <= winner_s;
                last_grant_r <= winner_s;
            end else begin
                grant_r      <= grant_r;
                last_grant_r <= last_grant_r;
            end
            if (state_r == BUSY) begin
                wdog_cnt_r <= wdog_cnt_r + 16'd1;
            end else begin
                wdog_cnt_r <= 16'd0;
            end
        end
    end

    // Response registers: loaded on the BUSY->DONE transition so they are live during DONE.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            host_ready_r   <= '0;
            host_rdata_r   <= '0;
            timeout_err_r  <= 1'b0;
            timeout_addr_r <= '0;
        end else begin
            timeout_err_r <= timeout_s;
            if (complete_s || timeout_s) begin
                host_ready_r <= HOST0_MASK << grant_r;
            end else begin
                host_ready_r <= '0;
            end
            if (complete_s) begin
                host_rdata_r <= periph_rdata;
            end else if (timeout_s) begin
                host_rdata_r <= TIMEOUT_RDATA;
            end else begin
                host_rdata_r <= host_rdata_r;
            end
            if (timeout_s) begin
                timeout_addr_r <= periph_addr;
            end else begin
                timeout_addr_r <= timeout_addr_r;
            end
        end
    end

    assign periph_valid = periph_valid_r;
    assign host_ready   = host_ready_r;
    assign host_rdata   = host_rdata_r;
    assign timeout_err  = timeout_err_r;
    assign timeout_addr = timeout_addr_r;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed bench for periph_bus_arbiter with two hosts and an 8-cycle watchdog.
module tb_periph_bus_arbiter;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic [1:0]  host_valid;
    logic [1:0]  host_ready;
    logic [63:0] host_addr;
    logic [63:0] host_wdata;
    logic [7:0]  host_wstrb;
    logic [31:0] host_rdata;
    logic        periph_valid;
    logic        periph_ready;
    logic [31:0] periph_addr;
    logic [31:0] periph_wdata;
    logic [3:0]  periph_wstrb;
    logic [31:0] periph_rdata;
    logic        timeout_err;
    logic [31:0] timeout_addr;

    int n_vec = 0;
    int n_err = 0;

    periph_bus_arbiter #(
        .NUM_HOSTS      (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .host_valid   (host_valid),
        .host_ready   (host_ready),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_wstrb   (host_wstrb),
        .host_rdata   (host_rdata),
        .periph_valid (periph_valid),
        .periph_ready (periph_ready),
        .periph_addr  (periph_addr),
        .periph_wdata (periph_wdata),
        .periph_wstrb (periph_wstrb),
        .periph_rdata (periph_rdata),
        .timeout_err  (timeout_err),
        .timeout_addr (timeout_addr)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst          = 1'b1;
        host_valid   = 2'b00;
        host_addr    = 64'd0;
        host_wdata   = 64'd0;
        host_wstrb   = 8'd0;
        periph_ready = 1'b0;
        periph_rdata = 32'd0;
        tick();
        tick();
        chk("rst_pvalid", {31'd0, periph_valid}, 32'd0);
        chk("rst_hready", {30'd0, host_ready}, 32'd0);
        chk("rst_hrdata", host_rdata, 32'd0);
        chk("rst_terr", {31'd0, timeout_err}, 32'd0);
        chk("rst_taddr", timeout_addr, 32'd0);
        rst = 1'b0;

        // single read, host 0, ready two cycles after valid
        host_addr[31:0] = 32'h0000_1000;
        host_valid      = 2'b01;
        tick();
        chk("t1_pvalid_c1", {31'd0, periph_valid}, 32'd1);
        chk("t1_addr", periph_addr, 32'h0000_1000);
        chk("t1_wstrb", {28'd0, periph_wstrb}, 32'd0);
        tick();
        chk("t1_pvalid_c2", {31'd0, periph_valid}, 32'd1);
        chk("t1_hready_c2", {30'd0, host_ready}, 32'd0);
        tick();
        chk("t1_pvalid_c3", {31'd0, periph_valid}, 32'd1);
        periph_ready = 1'b1;
        periph_rdata = 32'h1234_5678;
        tick();
        chk("t1_hready", {30'd0, host_ready}, 32'd1);
        chk("t1_hrdata", host_rdata, 32'h1234_5678);
        chk("t1_pvalid_done", {31'd0, periph_valid}, 32'd0);
        host_valid   = 2'b00;
        periph_ready = 1'b0;
        periph_rdata = 32'h0;
        tick();
        chk("t1_hready_after", {30'd0, host_ready}, 32'd0);
        chk("t1_hrdata_hold", host_rdata, 32'h1234_5678);

        // both hosts requesting continuously from reset: grants 0,1,0,1
        rst          = 1'b1;
        host_addr    = {32'h0000_4100, 32'h0000_4000};
        host_valid   = 2'b11;
        periph_ready = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            periph_rdata = 32'h0000_A000 + 32'(i);
            tick();
            chk("t2_pvalid_busy", {31'd0, periph_valid}, 32'd1);
            chk("t2_addr", periph_addr, (i % 2 == 0) ? 32'h0000_4000 : 32'h0000_4100);
            chk("t2_hready_busy", {30'd0, host_ready}, 32'd0);
            tick();
            chk("t2_hready", {30'd0, host_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("t2_hrdata", host_rdata, 32'h0000_A000 + 32'(i));
            chk("t2_pvalid_done", {31'd0, periph_valid}, 32'd0);
            host_valid = (i == 3) ? 2'b00 : 2'b11;
            tick();
            chk("t2_hready_idle", {30'd0, host_ready}, 32'd0);
            chk("t2_pvalid_idle", {31'd0, periph_valid}, 32'd0);
        end
        periph_ready = 1'b0;

        // write from host 1 while host 0 drives unrelated idle values
        host_addr  = {32'h0000_3000, 32'hFFFF_0000};
        host_wdata = {32'hCAFE_0001, 32'h0BAD_0BAD};
        host_wstrb = {4'b0011, 4'b1111};
        host_valid = 2'b10;
        tick();
        for (int j = 0; j < 3; j++) begin
            chk("t3_pvalid", {31'd0, periph_valid}, 32'd1);
            chk("t3_addr", periph_addr, 32'h0000_3000);
            chk("t3_wdata", periph_wdata, 32'hCAFE_0001);
            chk("t3_wstrb", {28'd0, periph_wstrb}, 32'h0000_0003);
            host_addr[31:0] = 32'hFFFF_0000 + 32'(j + 1);
            periph_ready    = (j == 2);
            tick();
        end
        chk("t3_hready", {30'd0, host_ready}, 32'd2);
        host_valid   = 2'b00;
        host_wstrb   = 8'd0;
        periph_ready = 1'b0;
        tick();

        // watchdog abort: valid high exactly 8 cycles
        host_addr[31:0] = 32'h0000_2004;
        host_valid      = 2'b01;
        tick();
        for (int j = 0; j < 8; j++) begin
            chk("t4_pvalid", {31'd0, periph_valid}, 32'd1);
            chk("t4_terr_busy", {31'd0, timeout_err}, 32'd0);
            tick();
        end
        chk("t4_pvalid_done", {31'd0, periph_valid}, 32'd0);
        chk("t4_terr", {31'd0, timeout_err}, 32'd1);
        chk("t4_taddr", timeout_addr, 32'h0000_2004);
        chk("t4_hrdata", host_rdata, 32'hDEAD_BEEF);
        chk("t4_hready", {30'd0, host_ready}, 32'd1);
        host_valid = 2'b00;
        tick();
        chk("t4_terr_pulse", {31'd0, timeout_err}, 32'd0);
        chk("t4_taddr_hold", timeout_addr, 32'h0000_2004);

        // ready on the last watchdog cycle completes normally
        host_addr[31:0] = 32'h0000_2008;
        host_valid      = 2'b01;
        tick();
        for (int j = 0; j < 8; j++) begin
            chk("t5_pvalid", {31'd0, periph_valid}, 32'd1);
            periph_ready = (j == 7);
            periph_rdata = 32'h5555_AAAA;
            tick();
        end
        chk("t5_terr", {31'd0, timeout_err}, 32'd0);
        chk("t5_hrdata", host_rdata, 32'h5555_AAAA);
        chk("t5_hready", {30'd0, host_ready}, 32'd1);
        chk("t5_taddr_hold", timeout_addr, 32'h0000_2004);
        host_valid   = 2'b00;
        periph_ready = 1'b0;
        tick();

        // reset in the middle of BUSY, then host 0 wins first
        host_addr  = {32'h0000_6100, 32'h0000_6000};
        host_valid = 2'b10;
        tick();
        chk("t6_addr_busy", periph_addr, 32'h0000_6100);
        chk("t6_pvalid_busy", {31'd0, periph_valid}, 32'd1);
        rst = 1'b1;
        tick();
        chk("t6_pvalid_rst", {31'd0, periph_valid}, 32'd0);
        chk("t6_hready_rst", {30'd0, host_ready}, 32'd0);
        chk("t6_terr_rst", {31'd0, timeout_err}, 32'd0);
        chk("t6_hrdata_rst", host_rdata, 32'd0);
        rst          = 1'b0;
        host_valid   = 2'b11;
        periph_ready = 1'b1;
        periph_rdata = 32'h0000_0066;
        tick();
        chk("t6_addr_first", periph_addr, 32'h0000_6000);
        tick();
        chk("t6_hready_first", {30'd0, host_ready}, 32'd1);
        chk("t6_hrdata_first", host_rdata, 32'h0000_0066);
        host_valid   = 2'b00;
        periph_ready = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
